// File: rtl/data_fsm_pkg.sv
// Shared types and widths for the three-word Aurora TX frame generator.
package data_fsm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = 4;
  localparam logic [KEEP_W-1:0] KEEP_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2,
    W3   = 2'd3
  } state_t;

endpackage

// File: rtl/data_fsm_if.sv
// Frame request inputs and AXI4-Stream-style output bundle for data_fsm.
interface data_fsm_if;
  import data_fsm_pkg::*;

  logic              en;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  logic [DATA_W-1:0] data_3;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic [KEEP_W-1:0] keep;

  // Frame generator side: consumes the request/words, sources the stream.
  modport master (
    input  en, data_1, data_2, data_3,
    output data, valid, last, keep
  );

  // Requester / stream sink side.
  modport slave (
    output en, data_1, data_2, data_3,
    input  data, valid, last, keep
  );

endinterface

// File: rtl/data_fsm.sv
// Three-word frame generator; outputs are registered from the next-state decode.
// Build option DATA_FSM_LATCH_EN: capture all three words when the frame is accepted.
module data_fsm
  import data_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  data_fsm_if.master bus
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              last_nxt;
  logic [KEEP_W-1:0] keep_nxt;
  logic [DATA_W-1:0] word_2;
  logic [DATA_W-1:0] word_3;

`ifdef DATA_FSM_LATCH_EN
  logic [DATA_W-1:0] word_2_q;
  logic [DATA_W-1:0] word_3_q;

  // Words 2 and 3 are frozen at the accepting edge; word 1 is loaded directly then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_2_q <= '0;
      word_3_q <= '0;
    end else if (state == IDLE && bus.en) begin
      word_2_q <= bus.data_2;
      word_3_q <= bus.data_3;
    end
  end

  assign word_2 = word_2_q;
  assign word_3 = word_3_q;
`else
  assign word_2 = bus.data_2;
  assign word_3 = bus.data_3;
`endif

  // State and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bus.data  <= '0;
      bus.valid <= 1'b0;
      bus.last  <= 1'b0;
      bus.keep  <= '0;
    end else begin
      state     <= state_nxt;
      bus.data  <= data_nxt;
      bus.valid <= valid_nxt;
      bus.last  <= last_nxt;
      bus.keep  <= keep_nxt;
    end
  end

  // Outputs are decoded from the state being entered so they land with it.
  always_comb begin
    state_nxt = state;
    data_nxt  = '0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    keep_nxt  = '0;
    unique case (state)
      IDLE: begin
        if (bus.en) begin
          state_nxt = W1;
          data_nxt  = bus.data_1;
          valid_nxt = 1'b1;
          keep_nxt  = KEEP_ALL;
        end
      end
      W1: begin
        state_nxt = W2;
        data_nxt  = word_2;
        valid_nxt = 1'b1;
        keep_nxt  = KEEP_ALL;
      end
      W2: begin
        state_nxt = W3;
        data_nxt  = word_3;
        valid_nxt = 1'b1;
        last_nxt  = 1'b1;
        keep_nxt  = KEEP_ALL;
      end
      W3: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_fsm.sv
// Self-checking bench for data_fsm: directed test-plan scenarios plus random traffic
// checked every cycle against a queue-based frame model.
module tb_data_fsm;
  import data_fsm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  data_fsm_if bus ();

  data_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: an accepted frame becomes a list of pending beats, ending in one forced idle beat.
  typedef struct {
    bit          idle;
    int          idx;
    logic [31:0] cap;
  } beat_t;

  beat_t       q[$];
  beat_t       b;
  logic [31:0] exp_data  = '0;
  logic        exp_valid = 1'b0;
  logic        exp_last  = 1'b0;
  bit          started   = 1'b0;

  always @(posedge clk) begin
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    if (!reset) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (bus.en) begin
        exp_data  = bus.data_1;
        exp_valid = 1'b1;
        q.push_back('{1'b0, 2, bus.data_2});
        q.push_back('{1'b0, 3, bus.data_3});
        q.push_back('{1'b1, 0, 32'h0});
      end
    end else begin
      b = q.pop_front();
      if (!b.idle) begin
        exp_valid = 1'b1;
        exp_last  = (b.idx == 3);
`ifdef DATA_FSM_LATCH_EN
        exp_data  = b.cap;
`else
        exp_data  = (b.idx == 2) ? bus.data_2 : bus.data_3;
`endif
      end
    end
    started = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("data",  bus.data, exp_data);
      chk("valid", 32'(bus.valid), 32'(exp_valid));
      chk("last",  32'(bus.last), 32'(exp_last));
      chk("keep",  32'(bus.keep), exp_valid ? 32'hF : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] a, input logic [31:0] b2, input logic [31:0] c);
    bus.data_1 = a;
    bus.data_2 = b2;
    bus.data_3 = c;
  endtask

  // One-cycle en pulse, then literal checks on each beat and the idle cycle after.
  task automatic frame_lit(input logic [31:0] a, input logic [31:0] b2, input logic [31:0] c);
    set_words(a, b2, c);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    chk("lit_w1", bus.data, a);
    chk("lit_w1_keep", 32'(bus.keep), 32'hF);
    chk("lit_w1_last", 32'(bus.last), 32'h0);
    tick();
    chk("lit_w2", bus.data, b2);
    chk("lit_w2_last", 32'(bus.last), 32'h0);
    tick();
    chk("lit_w3", bus.data, c);
    chk("lit_w3_last", 32'(bus.last), 32'h1);
    tick();
    chk("lit_idle_valid", 32'(bus.valid), 32'h0);
    chk("lit_idle_keep", 32'(bus.keep), 32'h0);
  endtask

  logic [6:0]  vpat;
  logic [31:0] exp_w2;

  initial begin
    bus.en = 1'b1;
    set_words(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);

    // Reset held with en high: nothing may start.
    tick();
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_data", bus.data, 32'h0);
    tick();
    chk("rst_last", 32'(bus.last), 32'h0);
    chk("rst_keep", 32'(bus.keep), 32'h0);
    bus.en = 1'b0;
    reset  = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.valid), 32'h0);

    frame_lit(32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h1990_0614);
    repeat (10) tick();
    frame_lit(32'h1234_5678, 32'h9876_5432, 32'hABCD_EF01);

    // en held high for seven edges: W1 W2 W3 idle W1 W2 W3.
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      vpat[6-i] = bus.valid;
    end
    bus.en = 1'b0;
    chk("held_en_valid_pattern", 32'(vpat), 32'h77);
    chk("held_en_last_on_w3", 32'(bus.last), 32'h1);
    tick();

    // Reset during W2 aborts the frame.
    set_words(32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    tick();
    chk("abort_w2", bus.data, 32'hB1B1_B1B1);
    reset = 1'b0;
    tick();
    chk("abort_valid", 32'(bus.valid), 32'h0);
    chk("abort_last", 32'(bus.last), 32'h0);
    reset = 1'b1;
    tick();
    chk("abort_stay_idle", 32'(bus.valid), 32'h0);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    chk("restart_w1", bus.data, 32'hA0A0_A0A0);
    repeat (4) tick();

    // data_2 changed during W1: captured build keeps it, live build follows it.
    set_words(32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h1990_0614);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    bus.data_2 = 32'h0;
    tick();
`ifdef DATA_FSM_LATCH_EN
    exp_w2 = 32'hCAFE_BABE;
`else
    exp_w2 = 32'h0;
`endif
    chk("latch_w2", bus.data, exp_w2);
    repeat (3) tick();

    // Random traffic with occasional resets, checked by the model.
    for (int i = 0; i < 2000; i++) begin
      bus.en     = 1'($urandom_range(0, 1));
      bus.data_1 = $urandom;
      bus.data_2 = $urandom;
      bus.data_3 = $urandom;
      reset      = ($urandom_range(0, 31) != 0);
      tick();
    end
    reset  = 1'b1;
    bus.en = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
